// File: rtl/adder_pkg.sv
// Shared types for the 8-bit adder datapath and its downstream sum FIFO.
package adder_pkg;

  localparam int OPERAND_W = 8;
  localparam int SUM_W     = OPERAND_W + 1;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [SUM_W-1:0]     sum_t;

  // What the FIFO does at one clock edge.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } fifo_op_e;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    fifo_op_e op;
    case ({pop, push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/adder_sum_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module adder_sum_fifo_mem
  import adder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(sum_t),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adder_sum_fifo.sv
// First-word-fall-through FIFO holding adder sums for the consumer.
// Define ADDER_SUM_FIFO_STATS_EN to add the carry_cnt/drop_cnt statistics ports.
module adder_sum_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SUM_W = $bits(sum_t),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef ADDER_SUM_FIFO_STATS_EN
  ,
  output logic [15:0]      carry_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [SUM_W-1:0] rd_data;
  logic             push;
  logic             pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full && !reset;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is never reset, so mask it until a real entry is present.
  assign out_sum   = out_valid ? rd_data : '0;
  assign out_carry = out_sum[SUM_W-1];

  adder_sum_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (SUM_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (sum),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case (fifo_op(push, pop))
        OP_PUSH: count <= count + CNT_W'(1);
        OP_POP:  count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ADDER_SUM_FIFO_STATS_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push && sum[SUM_W-1] && (carry_cnt != STAT_MAX)) begin
        carry_cnt <= carry_cnt + 16'd1;
      end
      if (in_valid && full && (drop_cnt != STAT_MAX)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`else
  // Statistics build option disabled: no counters exist.
`endif

endmodule

// File: tb/tb_adder_sum_fifo.sv
// Self-checking bench for adder_sum_fifo against a queue-based reference model.
module tb_adder_sum_fifo;
  import adder_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             out_carry;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
`ifdef ADDER_SUM_FIFO_STATS_EN
  logic [15:0]      carry_cnt;
  logic [15:0]      drop_cnt;
`endif

  int tests = 0;
  int failures = 0;

  sum_t model[$];
  int   model_carry = 0;
  int   model_drop = 0;

  adder_sum_fifo #(
    .DEPTH (DEPTH),
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef ADDER_SUM_FIFO_STATS_EN
    ,
    .carry_cnt (carry_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the reference queue.
  task automatic checkOutput(input string tag);
    sum_t exp_sum;
    exp_sum = (model.size() != 0) ? model[0] : '0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(model.size() != 0));
    chk({tag, ".out_sum"},   32'(out_sum),   32'(exp_sum));
    chk({tag, ".out_carry"}, 32'(out_carry), 32'(exp_sum[SUM_W-1]));
    chk({tag, ".count"},     32'(count),     32'(model.size()));
    chk({tag, ".full"},      32'(full),      32'(model.size() == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(model.size() == 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!reset && model.size() < DEPTH));
`ifdef ADDER_SUM_FIFO_STATS_EN
    chk({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(model_carry));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(model_drop));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic iv, input sum_t s, input logic ordy, input string tag);
    logic do_push;
    logic do_pop;
    in_valid  = iv;
    sum       = s;
    out_ready = ordy;
    do_push = iv && (model.size() < DEPTH);
    do_pop  = ordy && (model.size() != 0);
    if (do_push && s[SUM_W-1] && model_carry < 65535) model_carry++;
    if (iv && model.size() == DEPTH && model_drop < 65535) model_drop++;
    @(posedge clk);
    #1;
    if (do_pop) void'(model.pop_front());
    if (do_push) model.push_back(s);
    checkOutput(tag);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model.delete();
    model_carry = 0;
    model_drop = 0;
    @(posedge clk);
    #1;
    checkOutput("in_reset");
    reset = 1'b0;
    #1;
  endtask

  initial begin
    sum_t held;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sum = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold");
    reset = 1'b0;
    #1;
    checkOutput("reset_release");
    applyStimulus(1'b0, '0, 1'b0, "idle");

    // Single push of 255+255 then pop
    applyStimulus(1'b1, 9'h1FE, 1'b0, "single_push");
    chk("single_carry", 32'(out_carry), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, "single_pop");
    chk("single_empty", 32'(empty), 32'd1);

    // Fill to full, rejected 9th push, then drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, sum_t'(i), 1'b0, "fill");
    chk("fill_full", 32'(full), 32'd1);
    applyStimulus(1'b1, 9'h0AA, 1'b0, "push_when_full");
    chk("full_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(out_sum), 32'(i));
      applyStimulus(1'b0, '0, 1'b1, "drain");
    end

    // Continuous streaming of n*3 with both sides always ready
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, sum_t'(n * 3), 1'b1, "stream");
      chk("stream_count", 32'(count), 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, "stream_flush");

    // Back-pressure with out_ready toggling and random arrivals
    for (int k = 0; k < 60; k++) begin
      logic ordy;
      ordy = k[0];
      held = (model.size() != 0) ? model[0] : '0;
      applyStimulus(1'($urandom_range(0, 1)), sum_t'($urandom_range(0, 511)), ordy, "bp");
      if (!ordy && held != '0) chk("bp_stall_hold", 32'(out_sum), 32'(held));
    end

    // Fully random traffic
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), sum_t'($urandom), 1'($urandom_range(0, 2) != 0), "rand");
    end

    // Asynchronous reset with five entries held
    while (model.size() > 0) applyStimulus(1'b0, '0, 1'b1, "pre_drain");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, sum_t'(9'h100 + i), 1'b0, "pre_fill");
    chk("pre_reset_count", 32'(count), 32'd5);
    #2;
    reset = 1'b1;
    model.delete();
    model_carry = 0;
    model_drop = 0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    applyStimulus(1'b1, 9'h055, 1'b0, "post_reset_push");
    chk("post_reset_sum", 32'(out_sum), 32'h055);
    applyStimulus(1'b0, '0, 1'b1, "post_reset_pop");

`ifdef ADDER_SUM_FIFO_STATS_EN
    // Statistics: three carry pushes, then two refused pushes while full
    pulseReset();
    applyStimulus(1'b1, 9'h100, 1'b0, "stat_carry");
    applyStimulus(1'b1, 9'h1FF, 1'b0, "stat_carry");
    applyStimulus(1'b1, 9'h180, 1'b0, "stat_carry");
    for (int i = 0; i < DEPTH - 3; i++) applyStimulus(1'b1, sum_t'(i), 1'b0, "stat_fill");
    applyStimulus(1'b1, 9'h1AA, 1'b0, "stat_drop");
    applyStimulus(1'b1, 9'h1AA, 1'b0, "stat_drop");
    applyStimulus(1'b0, '0, 1'b0, "stat_settle");
    chk("carry_cnt_3", 32'(carry_cnt), 32'd3);
    chk("drop_cnt_2", 32'(drop_cnt), 32'd2);
`else
    pulseReset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
